// File: rtl/tile_net_iface.sv
// Tile-side network interface: buffers tile flits into the router's local input
// with stop-and-wait req/ack, and captures router-ejected flits into a drop-counting FIFO.
module tile_net_iface #(
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 4,
  parameter int FLIT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inj_valid,
  input  logic [FLIT_W-1:0] inj_flit,
  output logic              inj_ready,
  output logic              rtr_req_out,
  output logic [FLIT_W-1:0] rtr_flit_out,
  input  logic              rtr_ack_in,
  input  logic              rtr_req_in,
  input  logic [FLIT_W-1:0] rtr_flit_in,
  output logic              ej_valid,
  output logic [FLIT_W-1:0] ej_flit,
  input  logic              ej_ready,
  output logic [7:0]        drop_cnt
);

  localparam int INJ_AW = $clog2(INJ_DEPTH);
  localparam int INJ_CW = $clog2(INJ_DEPTH + 1);
  localparam int EJ_AW  = $clog2(EJ_DEPTH);
  localparam int EJ_CW  = $clog2(EJ_DEPTH + 1);

  localparam logic [INJ_AW-1:0] INJ_PTR_ONE  = {{(INJ_AW-1){1'b0}}, 1'b1};
  localparam logic [INJ_CW-1:0] INJ_CNT_ONE  = {{(INJ_CW-1){1'b0}}, 1'b1};
  localparam logic [INJ_CW-1:0] INJ_CNT_FULL = INJ_CW'(INJ_DEPTH);
  localparam logic [EJ_AW-1:0]  EJ_PTR_ONE   = {{(EJ_AW-1){1'b0}}, 1'b1};
  localparam logic [EJ_CW-1:0]  EJ_CNT_ONE   = {{(EJ_CW-1){1'b0}}, 1'b1};
  localparam logic [EJ_CW-1:0]  EJ_CNT_FULL  = EJ_CW'(EJ_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } inj_state_t;

  // ---------------- inject path ----------------
  logic [FLIT_W-1:0] inj_mem_r [INJ_DEPTH];
  logic [INJ_AW-1:0] inj_rd_ptr_r;
  logic [INJ_AW-1:0] inj_wr_ptr_r;
  logic [INJ_CW-1:0] inj_cnt_r;
  logic [INJ_CW-1:0] inj_cnt_next_s;
  logic              inj_ready_s;
  logic              inj_push_s;
  logic              inj_pop_s;
  inj_state_t        state_r;
  inj_state_t        state_next_s;
  logic [FLIT_W-1:0] head_next_s;
  logic              req_r;
  logic [FLIT_W-1:0] flit_r;

  assign inj_ready_s  = (inj_cnt_r < INJ_CNT_FULL);
  assign inj_push_s   = inj_valid && inj_ready_s;
  assign inj_ready    = inj_ready_s;
  assign rtr_req_out  = req_r;
  assign rtr_flit_out = flit_r;

  // Inject FSM next state, pop decision and the head flit the next SEND will carry
  always_comb begin
    state_next_s = state_r;
    inj_pop_s    = 1'b0;
    head_next_s  = inj_mem_r[inj_rd_ptr_r];
    case (state_r)
      IDLE: begin
        if (inj_cnt_r != '0) begin
          state_next_s = SEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        state_next_s = WAIT;
      end
      WAIT: begin
        if (rtr_ack_in) begin
          inj_pop_s = 1'b1;
          // Last entry popped while a new one arrives: forward it straight to the output.
          if (inj_cnt_r == INJ_CNT_ONE) begin
            head_next_s = inj_flit;
          end else begin
            head_next_s = inj_mem_r[inj_rd_ptr_r + INJ_PTR_ONE];
          end
          if ((inj_cnt_r != INJ_CNT_ONE) || inj_push_s) begin
            state_next_s = SEND;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = SEND;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Inject occupancy after this cycle's push/pop
  always_comb begin
    inj_cnt_next_s = inj_cnt_r;
    case ({inj_push_s, inj_pop_s})
      2'b10:   inj_cnt_next_s = inj_cnt_r + INJ_CNT_ONE;
      2'b01:   inj_cnt_next_s = inj_cnt_r - INJ_CNT_ONE;
      default: inj_cnt_next_s = inj_cnt_r;
    endcase
  end

  // Inject storage write port
  always_ff @(posedge clk) begin
    if (inj_push_s) begin
      inj_mem_r[inj_wr_ptr_r] <= inj_flit;
    end
  end

  // Inject control state and registered router-facing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      inj_cnt_r    <= '0;
      inj_rd_ptr_r <= '0;
      inj_wr_ptr_r <= '0;
      req_r        <= 1'b0;
      flit_r       <= '0;
    end else begin
      state_r   <= state_next_s;
      inj_cnt_r <= inj_cnt_next_s;
      if (inj_push_s) begin
        inj_wr_ptr_r <= inj_wr_ptr_r + INJ_PTR_ONE;
      end
      if (inj_pop_s) begin
        inj_rd_ptr_r <= inj_rd_ptr_r + INJ_PTR_ONE;
      end
      req_r <= (state_next_s == SEND);
      if (state_next_s == SEND) begin
        flit_r <= head_next_s;
      end else begin
        flit_r <= flit_r;
      end
    end
  end

  // ---------------- eject path ----------------
  logic [FLIT_W-1:0] ej_mem_r [EJ_DEPTH];
  logic [EJ_AW-1:0]  ej_rd_ptr_r;
  logic [EJ_AW-1:0]  ej_wr_ptr_r;
  logic [EJ_CW-1:0]  ej_cnt_r;
  logic [EJ_CW-1:0]  ej_cnt_next_s;
  logic              ej_valid_s;
  logic              ej_push_s;
  logic              ej_pop_s;
  logic              ej_drop_s;
  logic [7:0]        drop_r;

  // The router cannot be stalled, so a flit that finds no room is counted and discarded.
  assign ej_valid_s = (ej_cnt_r != '0);
  assign ej_pop_s   = ej_valid_s && ej_ready;
  assign ej_push_s  = rtr_req_in && ((ej_cnt_r < EJ_CNT_FULL) || ej_pop_s);
  assign ej_drop_s  = rtr_req_in && !ej_push_s;
  assign ej_valid   = ej_valid_s;
  assign ej_flit    = ej_mem_r[ej_rd_ptr_r];
  assign drop_cnt   = drop_r;

  // Eject occupancy after this cycle's push/pop
  always_comb begin
    ej_cnt_next_s = ej_cnt_r;
    case ({ej_push_s, ej_pop_s})
      2'b10:   ej_cnt_next_s = ej_cnt_r + EJ_CNT_ONE;
      2'b01:   ej_cnt_next_s = ej_cnt_r - EJ_CNT_ONE;
      default: ej_cnt_next_s = ej_cnt_r;
    endcase
  end

  // Eject storage write port
  always_ff @(posedge clk) begin
    if (ej_push_s) begin
      ej_mem_r[ej_wr_ptr_r] <= rtr_flit_in;
    end
  end

  // Eject pointers, occupancy and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ej_cnt_r    <= '0;
      ej_rd_ptr_r <= '0;
      ej_wr_ptr_r <= '0;
      drop_r      <= 8'd0;
    end else begin
      ej_cnt_r <= ej_cnt_next_s;
      if (ej_push_s) begin
        ej_wr_ptr_r <= ej_wr_ptr_r + EJ_PTR_ONE;
      end
      if (ej_pop_s) begin
        ej_rd_ptr_r <= ej_rd_ptr_r + EJ_PTR_ONE;
      end
      if (ej_drop_s && (drop_r != 8'hFF)) begin
        drop_r <= drop_r + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_tile_net_iface.sv
// Directed, table-driven bench for tile_net_iface: per-cycle vectors with
// hand-computed expectations, plus hand-written saturation and reset sequences.
module tb_tile_net_iface;

  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          inj_valid = 1'b0;
  logic [FW-1:0] inj_flit = '0;
  logic          inj_ready;
  logic          rtr_req_out;
  logic [FW-1:0] rtr_flit_out;
  logic          rtr_ack_in = 1'b0;
  logic          rtr_req_in = 1'b0;
  logic [FW-1:0] rtr_flit_in = '0;
  logic          ej_valid;
  logic [FW-1:0] ej_flit;
  logic          ej_ready = 1'b0;
  logic [7:0]    drop_cnt;

  tile_net_iface #(.INJ_DEPTH(4), .EJ_DEPTH(4), .FLIT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_ready(inj_ready),
    .rtr_req_out(rtr_req_out), .rtr_flit_out(rtr_flit_out), .rtr_ack_in(rtr_ack_in),
    .rtr_req_in(rtr_req_in), .rtr_flit_in(rtr_flit_in),
    .ej_valid(ej_valid), .ej_flit(ej_flit), .ej_ready(ej_ready),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [FW-1:0] ifl;
    logic          ack;
    logic          rq;
    logic [FW-1:0] rfl;
    logic          er;
    logic          x_ir;
    logic          x_req;
    logic [FW-1:0] x_fo;
    logic          x_ev;
    logic [FW-1:0] x_ef;
    logic [7:0]    x_dc;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic prev_req = 1'b0;
  logic double_req = 1'b0;

  // Flags any two consecutive cycles with rtr_req_out high.
  always @(negedge clk) begin
    if (rtr_req_out && prev_req) double_req = 1'b1;
    prev_req = rtr_req_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic iv, input logic [FW-1:0] ifl, input logic ack,
                     input logic rq, input logic [FW-1:0] rfl, input logic er,
                     input logic x_ir, input logic x_req, input logic [FW-1:0] x_fo,
                     input logic x_ev, input logic [FW-1:0] x_ef, input logic [7:0] x_dc);
    vec_t v;
    v.iv = iv; v.ifl = ifl; v.ack = ack; v.rq = rq; v.rfl = rfl; v.er = er;
    v.x_ir = x_ir; v.x_req = x_req; v.x_fo = x_fo; v.x_ev = x_ev; v.x_ef = x_ef; v.x_dc = x_dc;
    vq.push_back(v);
  endtask

  task automatic tick(input logic iv, input logic [FW-1:0] ifl, input logic ack,
                      input logic rq, input logic [FW-1:0] rfl, input logic er);
    inj_valid = iv; inj_flit = ifl; rtr_ack_in = ack;
    rtr_req_in = rq; rtr_flit_in = rfl; ej_ready = er;
    @(posedge clk);
    #1;
  endtask

  localparam logic [FW-1:0] A = 16'h0A0A;
  localparam logic [FW-1:0] P1 = 16'h1111, P2 = 16'h2222, P3 = 16'h3333, P4 = 16'h4444;
  localparam logic [FW-1:0] X = 16'hAA01, Y = 16'hAA02, Z = 16'hAA03;
  localparam logic [FW-1:0] F0 = 16'hF000, F1 = 16'hF001, F2 = 16'hF002;
  localparam logic [FW-1:0] F3 = 16'hF003, F4 = 16'hF004, F5 = 16'hF005, F6 = 16'hF006;

  initial begin
    // single inject: push at cycle 0, SEND at cycle 2, ack at 3, IDLE at 4
    add(1'b1, A, 1'b0, 1'b0, 16'h0, 1'b0,  1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0,  1'b1, 1'b1, A, 1'b0, 16'h0, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0,  1'b1, 1'b0, A, 1'b0, 16'h0, 8'd0);
    add(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0,  1'b1, 1'b0, A, 1'b0, 16'h0, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0,  1'b1, 1'b0, A, 1'b0, 16'h0, 8'd0);
    // burst of 4 with one retry of P1
    add(1'b1, P1, 1'b0, 1'b0, 16'h0, 1'b0,  1'b1, 1'b0, A,  1'b0, 16'h0, 8'd0);
    add(1'b1, P2, 1'b0, 1'b0, 16'h0, 1'b0,  1'b1, 1'b1, P1, 1'b0, 16'h0, 8'd0);
    add(1'b1, P3, 1'b0, 1'b0, 16'h0, 1'b0,  1'b1, 1'b0, P1, 1'b0, 16'h0, 8'd0);
    add(1'b1, P4, 1'b0, 1'b0, 16'h0, 1'b0,  1'b0, 1'b1, P1, 1'b0, 16'h0, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0,  1'b0, 1'b0, P1, 1'b0, 16'h0, 8'd0);
    add(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0,  1'b1, 1'b1, P2, 1'b0, 16'h0, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0,  1'b1, 1'b0, P2, 1'b0, 16'h0, 8'd0);
    add(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0,  1'b1, 1'b1, P3, 1'b0, 16'h0, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0,  1'b1, 1'b0, P3, 1'b0, 16'h0, 8'd0);
    add(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0,  1'b1, 1'b1, P4, 1'b0, 16'h0, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0,  1'b1, 1'b0, P4, 1'b0, 16'h0, 8'd0);
    add(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0,  1'b1, 1'b0, P4, 1'b0, 16'h0, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0,  1'b1, 1'b0, P4, 1'b0, 16'h0, 8'd0);
    // eject drain X,Y,Z with ej_ready high
    add(1'b0, 16'h0, 1'b0, 1'b1, X, 1'b1,  1'b1, 1'b0, P4, 1'b1, X, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b1, Y, 1'b1,  1'b1, 1'b0, P4, 1'b1, Y, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b1, Z, 1'b1,  1'b1, 1'b0, P4, 1'b1, Z, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1,  1'b1, 1'b0, P4, 1'b0, 16'h0, 8'd0);
    // overflow: 6 flits into a 4-deep FIFO with no consumer
    add(1'b0, 16'h0, 1'b0, 1'b1, F0, 1'b0,  1'b1, 1'b0, P4, 1'b1, F0, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b1, F1, 1'b0,  1'b1, 1'b0, P4, 1'b1, F0, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b1, F2, 1'b0,  1'b1, 1'b0, P4, 1'b1, F0, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b1, F3, 1'b0,  1'b1, 1'b0, P4, 1'b1, F0, 8'd0);
    add(1'b0, 16'h0, 1'b0, 1'b1, F4, 1'b0,  1'b1, 1'b0, P4, 1'b1, F0, 8'd1);
    add(1'b0, 16'h0, 1'b0, 1'b1, F5, 1'b0,  1'b1, 1'b0, P4, 1'b1, F0, 8'd2);
    // full FIFO with simultaneous pop: F6 stored, no drop, then drain F1,F2,F3,F6
    add(1'b0, 16'h0, 1'b0, 1'b1, F6, 1'b1,  1'b1, 1'b0, P4, 1'b1, F1, 8'd2);
    add(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1,  1'b1, 1'b0, P4, 1'b1, F2, 8'd2);
    add(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1,  1'b1, 1'b0, P4, 1'b1, F3, 8'd2);
    add(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1,  1'b1, 1'b0, P4, 1'b1, F6, 8'd2);
    add(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1,  1'b1, 1'b0, P4, 1'b0, 16'h0, 8'd2);

    // reset values while held in reset
    @(posedge clk); @(posedge clk); #1;
    check("rst_req_out", {31'd0, rtr_req_out}, 32'd0);
    check("rst_flit_out", {16'd0, rtr_flit_out}, 32'd0);
    check("rst_inj_ready", {31'd0, inj_ready}, 32'd1);
    check("rst_ej_valid", {31'd0, ej_valid}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    rst_n = 1'b1;
    prev_req = 1'b0;
    double_req = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      tick(vq[i].iv, vq[i].ifl, vq[i].ack, vq[i].rq, vq[i].rfl, vq[i].er);
      check($sformatf("v%0d_inj_ready", i), {31'd0, inj_ready}, {31'd0, vq[i].x_ir});
      check($sformatf("v%0d_req_out", i), {31'd0, rtr_req_out}, {31'd0, vq[i].x_req});
      check($sformatf("v%0d_flit_out", i), {16'd0, rtr_flit_out}, {16'd0, vq[i].x_fo});
      check($sformatf("v%0d_ej_valid", i), {31'd0, ej_valid}, {31'd0, vq[i].x_ev});
      if (vq[i].x_ev)
        check($sformatf("v%0d_ej_flit", i), {16'd0, ej_flit}, {16'd0, vq[i].x_ef});
      check($sformatf("v%0d_drop_cnt", i), {24'd0, drop_cnt}, {24'd0, vq[i].x_dc});
    end
    check("no_double_req", {31'd0, double_req}, 32'd0);

    // saturation: 300 more flits with no consumer; 4 stored, rest dropped from 2
    for (int i = 1; i <= 300; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b1, FW'(i), 1'b0);
      if (i == 256) check("drop_254", {24'd0, drop_cnt}, 32'd254);
      if (i == 257) check("drop_255", {24'd0, drop_cnt}, 32'd255);
    end
    check("drop_sat", {24'd0, drop_cnt}, 32'd255);
    check("sat_head", {16'd0, ej_flit}, 32'd1);

    // reset mid-flight: inject FIFO full and FSM in WAIT, eject FIFO full
    tick(1'b1, P1, 1'b0, 1'b0, 16'h0, 1'b0);
    tick(1'b1, P2, 1'b0, 1'b0, 16'h0, 1'b0);
    tick(1'b1, P3, 1'b0, 1'b0, 16'h0, 1'b0);
    tick(1'b1, P4, 1'b0, 1'b0, 16'h0, 1'b0);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("pre_rst_inj_ready", {31'd0, inj_ready}, 32'd0);
    check("pre_rst_ej_valid", {31'd0, ej_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req_out", {31'd0, rtr_req_out}, 32'd0);
    check("mid_rst_inj_ready", {31'd0, inj_ready}, 32'd1);
    check("mid_rst_ej_valid", {31'd0, ej_valid}, 32'd0);
    check("mid_rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    // late ack lands in IDLE and must be ignored
    tick(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("late_ack_req", {31'd0, rtr_req_out}, 32'd0);
    check("late_ack_ready", {31'd0, inj_ready}, 32'd1);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("late_ack_idle", {31'd0, rtr_req_out}, 32'd0);
    // FIFO still sane after reset: a fresh flit goes out two cycles later
    tick(1'b1, F5, 1'b0, 1'b0, 16'h0, 1'b0);
    check("post_rst_push_req", {31'd0, rtr_req_out}, 32'd0);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("post_rst_send_req", {31'd0, rtr_req_out}, 32'd1);
    check("post_rst_send_flit", {16'd0, rtr_flit_out}, {16'd0, F5});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tile_net_iface.md
# tile_net_iface

Network interface between an execution tile and the LOCAL port of its operand-network router. Buffers tile-produced flits and injects them into the router's local input with a stop-and-wait req/ack protocol. Captures flits the router ejects on its local output into an eject FIFO for the tile to drain. Counts ejected flits lost to eject-FIFO overflow.

## Interface
- `INJ_DEPTH`, default 4: inject FIFO entries, power of 2, ≥2.
- `EJ_DEPTH`, default 4: eject FIFO entries, power of 2, ≥2.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inj_valid`  in  1  tile offers `inj_flit`.
- `inj_flit`  in  generic_flit_t  flit to inject.
- `inj_ready`  out  1  inject FIFO can accept this cycle.
- `rtr_req_out`  out  1  drives router local `req_in`; registered.
- `rtr_flit_out`  out  generic_flit_t  drives router local `flit_in`; registered.
- `rtr_ack_in`  in  1  router local `ack_out`, one cycle after acceptance.
- `rtr_req_in`  in  1  router local `req_out` (flit present this cycle).
- `rtr_flit_in`  in  generic_flit_t  router local `flit_out`.
- `ej_valid`  out  1  eject FIFO non-empty.
- `ej_flit`  out  generic_flit_t  eject FIFO head, combinational from storage.
- `ej_ready`  in  1  tile consumes head.
- `drop_cnt`  out  8  saturating count of dropped ejected flits.

## Operation
- **Inject FIFO**
  - Push on `inj_valid && inj_ready`.
  - `inj_ready` = registered count < `INJ_DEPTH`; no same-cycle pop bypass.
  - Pointers wrap modulo depth; the count is `$clog2(INJ_DEPTH+1)` bits wide.
- **Inject FSM**, states IDLE, SEND, WAIT.
  - IDLE: if count > 0, go to SEND.
  - SEND: `rtr_req_out`=1 and `rtr_flit_out`=head for exactly this one cycle; always go to WAIT.
  - WAIT: `rtr_req_out`=0.
    - If `rtr_ack_in`=1: pop head; go to SEND if post-pop count > 0, else IDLE.
    - If `rtr_ack_in`=0 (router full): go to SEND and retry the same head.
  - `rtr_ack_in` in IDLE or SEND is ignored.
  - `rtr_req_out` is never high on two consecutive cycles, so the router cannot double-push. Peak throughput is 1 flit per 2 cycles.
  - `rtr_flit_out` holds its last value when not in SEND.
- **Eject FIFO**
  - The router pops on grant with no backpressure, so every `rtr_req_in`=1 cycle must be captured or dropped.
  - Push when `rtr_req_in` and (count < `EJ_DEPTH` or `ej_valid && ej_ready` in the same cycle).
  - Otherwise drop the flit and increment `drop_cnt`, saturating at 255.
  - Pop on `ej_valid && ej_ready`. Simultaneous push/pop leaves count unchanged.
- **Independence:** inject and eject paths share no state; simultaneous activity on both has no interaction.

## Timing
- **Reset values:** FIFOs empty; FSM IDLE; `rtr_req_out`=0; `rtr_flit_out`='0; `drop_cnt`=0; `ej_valid`=0; `inj_ready`=1.
- **Inject latency:** flit pushed at cycle t, FSM SEND at t+2 (`rtr_req_out` high), ack sampled in WAIT at t+3, pop visible at t+4.
- **Back-to-back injection:** SEND/WAIT alternate with no IDLE gap while the FIFO is non-empty.
- **Eject latency:** flit captured at edge ending the `rtr_req_in` cycle; `ej_valid` high the next cycle.
- **Reset mid-operation:**
  - All state is cleared immediately and asynchronously; any buffered flits are lost.
  - A flit the router accepted but whose ack had not yet arrived remains in the router; its late ack lands in IDLE and is ignored.

## Test plan
- **Single inject:** push flit A at cycle 0, router acks at cycle 3 -> `rtr_req_out` high only at cycle 2 with A; pop at cycle 3; FSM IDLE at cycle 4; `inj_ready` stays 1.
- **Burst and retry:** push 4 flits, `inj_ready`=0 after the 4th, no ack on first WAIT -> A re-sent 2 cycles later; order A,B,C,D preserved; `rtr_req_out` never high on 2 consecutive cycles.
- **Eject drain:** `rtr_req_in` for 3 cycles with X,Y,Z, `ej_ready`=1 -> `ej_flit` X,Y,Z in order, `drop_cnt`=0.
- **Eject overflow:** `ej_ready`=0, 6 flits ejected with `EJ_DEPTH`=4 -> 4 stored, `drop_cnt`=2.
  - Same with 300 flits -> `drop_cnt`=255 (saturated).
- **Full with simultaneous pop:** eject FIFO full, `rtr_req_in`=1 and `ej_ready`=1 same cycle -> flit stored, count stays 4, no drop.
- **Reset mid-flight:** assert `rst_n`=0 in WAIT -> `rtr_req_out`=0, `inj_ready`=1, `ej_valid`=0 immediately.
  - A post-reset `rtr_ack_in` pulse causes no pop and no FSM transition.
